// File: rtl/request_index_allocator_if.sv
// Mapper/scheduler <-> request index allocator signal bundle.
// Latency: n/a (wiring only); alloc_grant/alloc_index are combinational from allocator state.
// Backpressure: alloc_grant=0 tells the mapper to hold alloc_req and retry; releases are never stalled.
//
// Ports (master = mapper/scheduler side, slave = allocator side):
//   alloc_req, alloc_type            : allocation request and pool select (0 = read, 1 = write)
//   alloc_grant, alloc_index         : grant and granted index
//   release_valid/type/index         : index returned by the scheduler
//   read/write_free_count, *_empty   : registered pool occupancy
//   release_err                      : sticky illegal-release flag
interface request_index_allocator_if #(
    parameter int READ_ENTRIES  = 16,
    parameter int WRITE_ENTRIES = 16
);
    localparam int IDX_W  = $clog2((READ_ENTRIES > WRITE_ENTRIES) ? READ_ENTRIES : WRITE_ENTRIES);
    localparam int RCNT_W = $clog2(READ_ENTRIES + 1);
    localparam int WCNT_W = $clog2(WRITE_ENTRIES + 1);

    // Request type: 0 selects the read pool, 1 selects the write pool.
    typedef logic r_type;

    logic              alloc_req;
    r_type             alloc_type;
    logic              alloc_grant;
    logic [IDX_W-1:0]  alloc_index;
    logic              release_valid;
    r_type             release_type;
    logic [IDX_W-1:0]  release_index;
    logic [RCNT_W-1:0] read_free_count;
    logic [WCNT_W-1:0] write_free_count;
    logic              read_empty;
    logic              write_empty;
    logic              release_err;

    modport master (
        output alloc_req, alloc_type, release_valid, release_type, release_index,
        input  alloc_grant, alloc_index, read_free_count, write_free_count,
               read_empty, write_empty, release_err
    );

    modport slave (
        input  alloc_req, alloc_type, release_valid, release_type, release_index,
        output alloc_grant, alloc_index, read_free_count, write_free_count,
               read_empty, write_empty, release_err
    );
endinterface

// File: rtl/request_index_allocator.sv
// Free-slot index allocator for the global read/write request arrays, one circular free list per pool.
// Latency: grant/index combinational in the request cycle; released index allocatable 1 cycle later.
// Backpressure: empty pool -> alloc_grant=0, mapper retries; a release into a full pool is dropped.
//
// Ports: clk, rst (asynchronous, active-low), bus (request_index_allocator_if.slave).
// Optional feature macro: RELEASE_CHECK_EN -- per-pool in-use bitmap; releases of indices not
// currently allocated (or out of range) are dropped and set the sticky release_err flag.
module request_index_allocator #(
    parameter int READ_ENTRIES  = 16,
    parameter int WRITE_ENTRIES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    request_index_allocator_if.slave        bus
);
    localparam int IDX_W  = $clog2((READ_ENTRIES > WRITE_ENTRIES) ? READ_ENTRIES : WRITE_ENTRIES);
    localparam int RCNT_W = $clog2(READ_ENTRIES + 1);
    localparam int WCNT_W = $clog2(WRITE_ENTRIES + 1);

    logic              r_pop, w_pop;
    logic              r_rel, w_rel;
    logic              r_drop, w_drop;
    logic [IDX_W-1:0]  r_head, w_head;
    logic [RCNT_W-1:0] r_cnt;
    logic [WCNT_W-1:0] w_cnt;
    logic              r_empty, w_empty;

    assign r_empty = (r_cnt == '0);
    assign w_empty = (w_cnt == '0);

    // No bypass: grant depends only on registered counts, so a same-cycle release
    // into an empty pool is granted on the following cycle.
    assign bus.alloc_grant = bus.alloc_req && (bus.alloc_type ? !w_empty : !r_empty);
    assign bus.alloc_index = !bus.alloc_grant ? '0 : (bus.alloc_type ? w_head : r_head);

    assign r_pop = bus.alloc_grant && !bus.alloc_type;
    assign w_pop = bus.alloc_grant &&  bus.alloc_type;
    assign r_rel = bus.release_valid && !bus.release_type;
    assign w_rel = bus.release_valid &&  bus.release_type;

    request_index_pool #(.N(READ_ENTRIES), .IDX_W(IDX_W), .CNT_W(RCNT_W)) u_read_pool (
        .clk        (clk),
        .rst        (rst),
        .pop        (r_pop),
        .rel_vld    (r_rel),
        .rel_idx    (bus.release_index),
        .head_idx   (r_head),
        .free_count (r_cnt),
        .drop       (r_drop)
    );

    request_index_pool #(.N(WRITE_ENTRIES), .IDX_W(IDX_W), .CNT_W(WCNT_W)) u_write_pool (
        .clk        (clk),
        .rst        (rst),
        .pop        (w_pop),
        .rel_vld    (w_rel),
        .rel_idx    (bus.release_index),
        .head_idx   (w_head),
        .free_count (w_cnt),
        .drop       (w_drop)
    );

    assign bus.read_free_count  = r_cnt;
    assign bus.write_free_count = w_cnt;
    assign bus.read_empty       = r_empty;
    assign bus.write_empty      = w_empty;

`ifdef RELEASE_CHECK_EN
    // Sticky until reset so software can spot a scheduler that returned a bogus index.
    logic err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (r_drop || w_drop) begin
            err_q <= 1'b1;
        end
    end
    assign bus.release_err = err_q;
`else
    // A release into a full pool is still dropped, but it is not reported.
    logic unused_drop;
    assign unused_drop     = r_drop | w_drop;
    assign bus.release_err = 1'b0;
`endif
endmodule

// One pool: N-entry circular free list of indices with head/tail pointers and a free count.
// Latency: head_idx is the registered FIFO head; pop/push take effect at the next rising edge.
// Backpressure: caller must only pop when free_count != 0; pushes into a full list are dropped.
module request_index_pool #(
    parameter int N     = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop,
    input  logic             rel_vld,
    input  logic [IDX_W-1:0] rel_idx,
    output logic [IDX_W-1:0] head_idx,
    output logic [CNT_W-1:0] free_count,
    output logic             drop
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] entry [N];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             accept;

    // Explicit wrap so non-power-of-two pool sizes still cycle N-1 -> 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full = (count == CNT_W'(N));

`ifdef RELEASE_CHECK_EN
    logic [N-1:0] in_use;
    logic         rel_live;

    // An out-of-range index matches no bitmap position and so reads as not live.
    always_comb begin
        rel_live = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rel_idx == IDX_W'(i)) begin
                rel_live = in_use[i];
            end
        end
    end

    assign accept = rel_vld && !full && rel_live;

    // The popped index is free (bit 0) and the accepted one is live (bit 1), so they never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_use <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pop && (entry[head] == IDX_W'(i))) begin
                    in_use[i] <= 1'b1;
                end else if (accept && (rel_idx == IDX_W'(i))) begin
                    in_use[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign accept = rel_vld && !full;
`endif

    assign drop       = rel_vld && !accept;
    assign head_idx   = entry[head];
    assign free_count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                entry[i] <= IDX_W'(i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(N);
        end else begin
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (accept) begin
                entry[tail] <= rel_idx;
                tail        <= ptr_inc(tail);
            end
            // Simultaneous pop and push leave the count unchanged.
            if (pop && !accept) begin
                count <= count - CNT_W'(1);
            end else if (!pop && accept) begin
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_request_index_allocator.sv
// Self-checking bench for request_index_allocator: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based free-list model.
module tb_request_index_allocator;
    localparam int RN = 16;
    localparam int WN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    request_index_allocator_if #(.READ_ENTRIES(RN), .WRITE_ENTRIES(WN)) ifc ();

    request_index_allocator #(.READ_ENTRIES(RN), .WRITE_ENTRIES(WN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Reference model: free lists as queues, allocation takes the front, releases append.
    int q_r[$];
    int q_w[$];
    int out_r[$];
    int out_w[$];
    bit use_r[RN];
    bit use_w[WN];
    bit m_err;

    int n_cmp = 0;
    int n_bad = 0;

    bit e_grant;
    int e_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q_r.delete();
        q_w.delete();
        out_r.delete();
        out_w.delete();
        for (int i = 0; i < RN; i++) begin
            q_r.push_back(i);
            use_r[i] = 1'b0;
        end
        for (int i = 0; i < WN; i++) begin
            q_w.push_back(i);
            use_w[i] = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_step();
        bit g;
        bit acc;
        int ridx;
        int gi;
        g    = ifc.alloc_req && ((ifc.alloc_type ? q_w.size() : q_r.size()) != 0);
        ridx = int'(ifc.release_index);
        acc  = 1'b0;
        if (ifc.release_valid) begin
            if (ifc.release_type) acc = (q_w.size() != WN);
            else                  acc = (q_r.size() != RN);
`ifdef RELEASE_CHECK_EN
            if (ifc.release_type) acc = acc && (ridx < WN) && use_w[ridx];
            else                  acc = acc && (ridx < RN) && use_r[ridx];
            if (!acc) m_err = 1'b1;
`endif
        end
        if (g) begin
            if (ifc.alloc_type) begin
                gi = q_w.pop_front();
                use_w[gi] = 1'b1;
                out_w.push_back(gi);
            end else begin
                gi = q_r.pop_front();
                use_r[gi] = 1'b1;
                out_r.push_back(gi);
            end
        end
        if (acc) begin
            if (ifc.release_type) begin
                q_w.push_back(ridx);
                use_w[ridx] = 1'b0;
            end else begin
                q_r.push_back(ridx);
                use_r[ridx] = 1'b0;
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        e_grant = ifc.alloc_req && ((ifc.alloc_type ? q_w.size() : q_r.size()) != 0);
        e_idx   = e_grant ? (ifc.alloc_type ? q_w[0] : q_r[0]) : 0;
        check("grant",            ifc.alloc_grant,      e_grant);
        check("index",            ifc.alloc_index,      e_idx);
        check("read_free_count",  ifc.read_free_count,  q_r.size());
        check("write_free_count", ifc.write_free_count, q_w.size());
        check("read_empty",       ifc.read_empty,       q_r.size() == 0);
        check("write_empty",      ifc.write_empty,      q_w.size() == 0);
        check("release_err",      ifc.release_err,      m_err);
    end

    task automatic drive(input bit areq, input bit atype, input bit rv, input bit rt, input int ri);
        ifc.alloc_req     = areq;
        ifc.alloc_type    = atype;
        ifc.release_valid = rv;
        ifc.release_type  = rt;
        ifc.release_index = ri[3:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    int exp_seq[4] = '{13, 14, 15, 3};

    initial begin
        bit areq, atype, rv, rt;
        int ri, k, bias;

        model_reset();
        drive(0, 0, 0, 0, 0);
        #1;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst_grant",       ifc.alloc_grant,      0);
        check("rst_index",       ifc.alloc_index,      0);
        check("rst_read_count",  ifc.read_free_count,  16);
        check("rst_write_count", ifc.write_free_count, 16);
        check("rst_read_empty",  ifc.read_empty,       0);
        check("rst_err",         ifc.release_err,      0);
        step();

        // 16 back-to-back read allocations return 0..15, then the pool is empty.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0, 0);
            @(negedge clk);
            check("seq_grant", ifc.alloc_grant, 1);
            check("seq_index", ifc.alloc_index, i);
            check("seq_count", ifc.read_free_count, 16 - i);
            step();
        end
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        check("empty_grant", ifc.alloc_grant,     0);
        check("empty_count", ifc.read_free_count, 0);
        check("empty_flag",  ifc.read_empty,      1);
        step();

        // Release into an empty pool with a same-cycle alloc: no bypass.
        drive(1, 0, 1, 0, 7);
        @(negedge clk);
        check("nobypass_grant", ifc.alloc_grant, 0);
        step();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        check("retry_grant", ifc.alloc_grant, 1);
        check("retry_index", ifc.alloc_index, 7);
        step();
        drive(0, 0, 0, 0, 0);

        // Same-pool alloc + release with write count 5.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1, 1, 0, 0, 0);
            step();
        end
        drive(1, 1, 1, 1, 3);
        @(negedge clk);
        check("same_pool_pre_count", ifc.write_free_count, 5);
        check("same_pool_index",     ifc.alloc_index,      11);
        step();
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        check("same_pool_count", ifc.write_free_count, 5);
        check("same_pool_head",  ifc.alloc_index,      12);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0);
            @(negedge clk);
            check("same_pool_tail", ifc.alloc_index, exp_seq[i]);
            step();
        end
        drive(0, 0, 0, 0, 0);

        // Interleaved: alloc write, alloc read, release write 0.
        do_reset();
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        check("il_write_index", ifc.alloc_index, 0);
        step();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        check("il_read_index", ifc.alloc_index, 0);
        step();
        drive(0, 0, 1, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("il_write_count", ifc.write_free_count, 16);
        check("il_read_count",  ifc.read_free_count,  15);
        step();

`ifdef RELEASE_CHECK_EN
        // Release of a never-allocated index is dropped and flagged until reset.
        do_reset();
        drive(0, 0, 1, 0, 3);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("chk_count", ifc.read_free_count, 16);
        check("chk_err",   ifc.release_err,     1);
        step();
        step();
        step();
        @(negedge clk);
        check("chk_err_sticky", ifc.release_err, 1);
        do_reset();
        @(negedge clk);
        check("chk_err_cleared", ifc.release_err, 0);
        step();
`endif

        // Reset mid-stream with 9 read indices outstanding.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("midrst_count", ifc.read_free_count, 16);
        check("midrst_empty", ifc.read_empty,      0);
        step();
        step();
        rst = 1'b1;
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        check("midrst_index", ifc.alloc_index, 0);
        step();

        // Randomized traffic, alternating allocation-heavy and release-heavy phases.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bias  = ((cyc / 400) % 2 == 1) ? 1 : 3;
            areq  = ($urandom_range(0, 3) < bias);
            atype = $urandom_range(0, 1);
            rv = 1'b0;
            rt = 1'b0;
            ri = 0;
            if ($urandom_range(0, 31) == 0) begin
                rv = 1'b1;
                rt = $urandom_range(0, 1);
                ri = $urandom_range(0, 15);
            end else if ($urandom_range(0, 3) >= bias) begin
                rt = $urandom_range(0, 1);
                if (rt && out_w.size() > 0) begin
                    k  = $urandom_range(0, out_w.size() - 1);
                    ri = out_w[k];
                    out_w.delete(k);
                    rv = 1'b1;
                end else if (!rt && out_r.size() > 0) begin
                    k  = $urandom_range(0, out_r.size() - 1);
                    ri = out_r[k];
                    out_r.delete(k);
                    rv = 1'b1;
                end
            end
            drive(areq, atype, rv, rt, ri);
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/request_index_allocator.md
# request_index_allocator

Allocates free slot indices in the front-end global request storage. The mapper asks for an index before writing a request into the read or write array. The scheduler returns the index once the request has been read out. It keeps one circular free list per request type, read and write, so the mapper never overwrites a live entry. The block sits beside the global array, between the mapper and the scheduler.

## Interface
- READ_ENTRIES, 16, number of read-array slots; indices 0..READ_ENTRIES-1
- WRITE_ENTRIES, 16, number of write-array slots; indices 0..WRITE_ENTRIES-1
- IDX_W, $clog2(max(READ_ENTRIES,WRITE_ENTRIES)), index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- alloc_req  in  1  mapper requests an index
- alloc_type  in  r_type  pool to allocate from (read / write)
- alloc_grant  out  1  index granted this cycle
- alloc_index  out  IDX_W  granted index; valid only while alloc_grant=1
- release_valid  in  1  scheduler returns an index
- release_type  in  r_type  pool the index belongs to
- release_index  in  IDX_W  index being returned
- read_free_count  out  $clog2(READ_ENTRIES+1)  free read slots
- write_free_count  out  $clog2(WRITE_ENTRIES+1)  free write slots
- read_empty, write_empty  out  1  pool has zero free slots
- release_err  out  1  sticky illegal-release flag (see Configuration)

## Operation
- Each pool holds:
  - an N-entry index FIFO
  - head and tail pointers, each wrapping N-1 -> 0
  - a free count, 0..N
- Reset (rst=0, asynchronous):
  - entry[i]=i, head=0, tail=0, count=N, in both pools
  - outputs: alloc_grant=0, alloc_index=0, free counts = READ_ENTRIES / WRITE_ENTRIES, empties=0, release_err=0
  - reset mid-operation discards every outstanding allocation
- Allocation:
  - alloc_grant = alloc_req && count(alloc_type)!=0, combinational
  - alloc_index = entry[head] of the selected pool; 0 when there is no grant
  - on the edge after a grant: head++, count--
  - alloc_req on an empty pool -> alloc_grant=0 and no state change; the mapper holds the request and retries
- Release:
  - on the edge with release_valid=1 and the release accepted: entry[tail]=release_index, tail++, count++
  - a release while count==N is dropped
  - with RELEASE_CHECK_EN, a dropped release also sets release_err
- Simultaneous events:
  - alloc and release on different pools proceed independently
  - alloc and release on the same pool in one cycle: pop and push both occur, count is unchanged
  - no bypass: on an empty pool, a same-cycle release does not produce a grant; the grant comes next cycle
- The allocation order is FIFO in release order; after reset it is 0,1,2,...

## Timing
- Allocation is zero-latency: grant and index are combinational from registered state in the request cycle.
- The allocator's bookkeeping updates at the next rising edge.
- A released index becomes allocatable 1 cycle after release_valid.
- Free counts and empty flags reflect registered state; they update 1 cycle after the event.
- Throughput: 1 allocation and 1 release per cycle, in total across both pools.

## Configuration
- RELEASE_CHECK_EN defined:
  - each pool keeps an in-use bitmap: bit set on grant, cleared on accepted release
  - a release of an index whose bit is 0, or of an out-of-range index (>= N), is dropped with no FIFO push
  - the dropped release sets release_err, which clears only on reset
- RELEASE_CHECK_EN undefined:
  - no bitmap; releases are pushed unconditionally, except when count==N
  - release_err is tied to 0

## Test plan
- After reset: 16 consecutive read allocs -> indices 0..15, read_free_count 16->0, read_empty=1; 17th alloc_req -> alloc_grant=0.
- Read pool empty, then release read index 7 and alloc read in the same cycle -> no grant that cycle; next cycle grant with alloc_index=7.
- Same-pool alloc and release in one cycle with write count=5 -> write_free_count stays 5; head and tail both advance.
- Interleaved traffic: alloc write (index 0), alloc read (index 0), release write 0 -> write_free_count=16, read_free_count=15.
- With RELEASE_CHECK_EN: release read index 3 right after reset -> dropped, read_free_count stays 16, release_err=1 until rst.
- Assert rst mid-stream with 9 read indices allocated -> counts return to 16 immediately, next allocation returns index 0.
